// File: rtl/serial_echo_tx.sv
// Echo transmitter: queues host characters (CR expanded to CR+LF) and sends them as 8N1 frames.
// Define TX_PARITY_EN to add an even-parity bit (8E1 frames).
module serial_echo_tx #(
    parameter int unsigned CLKS_PER_BIT    = 434,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       sys_clk,
    input  logic                       RST,
    input  logic [7:0]                 char_in,
    input  logic                       newChar,
    input  logic                       tx_enable,
    input  logic                       clr_ovf,
    output logic                       tx,
    output logic                       tx_busy,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
    output logic                       overflow
);

    localparam int unsigned Depth  = 2 ** FIFO_DEPTH_LOG2;
    localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TimerW-1:0]          TimerMax  = TimerW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0]   CountFull = (FIFO_DEPTH_LOG2 + 1)'(Depth);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e                       state_q, state_d;
    logic [TimerW-1:0]            timer_q, timer_d;
    logic [2:0]                   bit_idx_q, bit_idx_d;
    logic [7:0]                   data_q, data_d;
    logic                         tx_q, tx_d;
    logic                         busy_q, busy_d;
    logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]     count_q, count_d;
    logic                         lf_pending_q, lf_pending_d;
    logic                         overflow_q, overflow_d;
    logic [7:0]                   mem_q [Depth];

    logic       bit_done;
    logic       pop;
    logic       push;
    logic [7:0] push_data;
    logic       strobe;
    logic       room;
    logic       ovf_set;

    assign bit_done = (timer_q == TimerMax);
    assign strobe   = newChar & tx_enable;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign room     = (count_q != CountFull) || pop;

    always_ff @(posedge sys_clk) begin
        if (RST) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            data_q       <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lf_pending_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            data_q       <= data_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lf_pending_q <= lf_pending_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Transmit FSM: next state plus the line level, which is registered into tx_q.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        pop       = 1'b0;
        tx_d      = 1'b1;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    state_d = StStart;
                end
            end
            StStart: begin
                tx_d    = 1'b0;
                timer_d = bit_done ? '0 : timer_q + 1'b1;
                if (bit_done) begin
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                tx_d    = data_q[bit_idx_q];
                timer_d = bit_done ? '0 : timer_q + 1'b1;
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef TX_PARITY_EN
            StParity: begin
                tx_d    = ^data_q;
                timer_d = bit_done ? '0 : timer_q + 1'b1;
                if (bit_done) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                tx_d    = 1'b1;
                timer_d = bit_done ? '0 : timer_q + 1'b1;
                if (bit_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO write side; a pending LF takes the slot ahead of any new strobe.
    always_comb begin
        push         = 1'b0;
        push_data    = char_in;
        lf_pending_d = 1'b0;
        ovf_set      = 1'b0;
        if (lf_pending_q) begin
            push_data = 8'h0A;
            ovf_set   = strobe | ~room;
            push      = room;
        end else if (strobe) begin
            if (room) begin
                push         = 1'b1;
                lf_pending_d = (char_in == 8'h0D);
            end else begin
                ovf_set = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
        busy_d     = (state_q != StIdle) || (count_q != '0);
    end

    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_echo_tx.sv
// Bench for serial_echo_tx: queue-based line model checked every cycle, plus literal frame checks.
module tb_serial_echo_tx;

    localparam int unsigned CPB = 4;
    localparam int unsigned L   = 4;
`ifdef TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic       new_char = 1'b0;
    logic       tx_enable = 1'b1;
    logic       clr_ovf = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic [L:0] fifo_count;
    logic       overflow;

    serial_echo_tx #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2 (L)
    ) dut (
        .sys_clk    (clk),
        .RST        (rst),
        .char_in    (char_in),
        .newChar    (new_char),
        .tx_enable  (tx_enable),
        .clr_ovf    (clr_ovf),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Line model: a byte queue plus a queue of expected per-cycle line levels.
    byte unsigned mq[$];
    bit           wave[$];
    int           frame_left = 0;
    bit           lf_pend = 0;
    bit           m_ovf = 0;
    bit           m_tx = 1;
    bit           m_busy = 0;
    int           m_cnt = 0;
    bit           model_valid = 0;

    function automatic bit frame_bit(input byte unsigned b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            wave.delete();
            frame_left  = 0;
            lf_pend     = 0;
            m_ovf       = 0;
            m_tx        = 1;
            m_busy      = 0;
            m_cnt       = 0;
            model_valid = 1;
        end else begin
            bit           do_pop;
            bit           strobe;
            bit           room;
            bit           ovf_set;
            byte unsigned b;
            m_busy = (frame_left != 0) || (mq.size() != 0);
            m_tx   = (wave.size() != 0) ? wave.pop_front() : 1'b1;
            do_pop = (frame_left == 0) && (mq.size() != 0);
            if (frame_left != 0) frame_left--;
            if (do_pop) begin
                b = mq.pop_front();
                frame_left = NBITS * CPB;
                for (int k = 0; k < NBITS; k++)
                    for (int j = 0; j < CPB; j++) wave.push_back(frame_bit(b, k));
            end
            strobe  = new_char && tx_enable;
            room    = mq.size() < (1 << L);
            ovf_set = 0;
            if (lf_pend) begin
                lf_pend = 0;
                if (strobe) ovf_set = 1;
                if (room) mq.push_back(8'h0A);
                else ovf_set = 1;
            end else if (strobe) begin
                if (room) begin
                    mq.push_back(char_in);
                    if (char_in == 8'h0D) lf_pend = 1;
                end else begin
                    ovf_set = 1;
                end
            end
            if (ovf_set) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            m_cnt = mq.size();
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_tx", tx, m_tx);
            check("model_tx_busy", tx_busy, m_busy);
            check("model_fifo_count", fifo_count, m_cnt);
            check("model_overflow", overflow, m_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic strobe(input logic [7:0] c);
        new_char = 1'b1;
        char_in  = c;
        tick();
        new_char = 1'b0;
    endtask

    // Strobe one byte from idle and compare every bit cell against a literal frame.
    task automatic send_and_check(input logic [7:0] c, input logic [10:0] frame, input string nm);
        strobe(c);
        tick();
        check({nm, "_pre_start"}, tx, 1'b1);
        for (int i = 0; i < NBITS; i++) begin
            for (int j = 0; j < CPB; j++) begin
                tick();
                check(nm, tx, frame[i]);
            end
        end
        check({nm, "_busy_in_stop"}, tx_busy, 1'b1);
        tick();
        check({nm, "_busy_end"}, tx_busy, 1'b0);
        check({nm, "_idle_tx"}, tx, 1'b1);
    endtask

    logic [10:0] f41;
    int          peak;

    initial begin
`ifdef TX_PARITY_EN
        f41 = {1'b1, 1'b0, 8'h41, 1'b0};
`else
        f41 = {1'b0, 1'b1, 8'h41, 1'b0};
`endif
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_count", fifo_count, 0);
        check("reset_ovf", overflow, 1'b0);
        tick();

        send_and_check(8'h41, f41, "frame_41");

        // CR expands to CR+LF with the queue never exceeding one entry.
        strobe(8'h0D);
        peak = fifo_count;
        for (int i = 0; i < 2 * (NBITS * CPB + 1) + 20; i++) begin
            tick();
            if (fifo_count > peak) peak = fifo_count;
        end
        check("crlf_peak", peak, 1);
        check("crlf_done", tx_busy, 1'b0);

        // 18 back-to-back strobes: one to the shifter, 16 queued, last dropped.
        new_char = 1'b1;
        for (int i = 0; i < 18; i++) begin
            char_in = 8'h30 + 8'(i);
            tick();
        end
        new_char = 1'b0;
        check("burst_count", fifo_count, 16);
        check("burst_ovf", overflow, 1'b1);
        for (int i = 0; i < 3000 && tx_busy; i++) tick();
        check("burst_drain", tx_busy, 1'b0);
        check("burst_ovf_sticky", overflow, 1'b1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", overflow, 1'b0);

        // Disabled echo ignores strobes.
        tx_enable = 1'b0;
        strobe(8'h55);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("disabled_tx", tx, 1'b1);
        end
        check("disabled_count", fifo_count, 0);
        check("disabled_ovf", overflow, 1'b0);
        tx_enable = 1'b1;

        // Reset during data bit 3 with three bytes queued.
        strobe(8'h41);
        strobe(8'h42);
        strobe(8'h43);
        strobe(8'h44);
        check("pre_reset_count", fifo_count, 3);
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_tx", tx, 1'b1);
        check("midrst_count", fifo_count, 0);
        check("midrst_busy", tx_busy, 1'b0);
        tick();
        send_and_check(8'h41, f41, "post_reset_41");

`ifdef TX_PARITY_EN
        send_and_check(8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, "parity_07");
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
